// File: rtl/nibble_serial_subtractor_ctrl.sv
// Purpose: sequences a WIDTH-bit subtraction a - b through one external 4-bit ripple stage, one nibble per cycle.
// Latency: done pulses NIBBLES cycles after the accepting edge; one operation per NIBBLES+1 cycles.
// Backpressure: none; start is only sampled in IDLE or DONE, and a start seen during RUN is ignored.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start, a, b            operation request; a and b are latched on the accepting edge
//   busy, done             busy is high in RUN; done is a one-cycle pulse when a result is valid
//   diff, borrow, overflow a - b modulo 2^WIDTH, unsigned borrow, signed overflow (held until the next result)
//   sub_a, sub_b, sub_cin  operand nibble, inverted subtrahend nibble and carry-in to the 4-bit stage
//   sub_s, sub_cout        combinational sum and carry-out returned by the 4-bit stage
module nibble_serial_subtractor_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic [3:0]       sub_a,
  output logic [3:0]       sub_b,
  output logic             sub_cin,
  input  logic [3:0]       sub_s,
  input  logic             sub_cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_r_q, a_r_d;
  logic [WIDTH-1:0]   b_r_q, b_r_d;
  logic [WIDTH-1:0]   diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Shift image with the nibble being computed this cycle already merged in,
  // so the last RUN edge can publish the complete result directly.
  logic [WIDTH-1:0]   result;
  logic               last_nib;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_r_d      = a_r_q;
    b_r_d      = b_r_q;
    diff_sh_d  = diff_sh_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;

    sub_a   = 4'd0;
    sub_b   = 4'd0;
    sub_cin = 1'b0;

    result                = diff_sh_q;
    result[4*idx_q +: 4]  = sub_s;
    last_nib              = (idx_q == IDX_W'(NIBBLES - 1));

    case (state_q)
      S_RUN: begin
        // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
        sub_a   = a_r_q[4*idx_q +: 4];
        sub_b   = ~b_r_q[4*idx_q +: 4];
        sub_cin = carry_q;

        diff_sh_d = result;
        carry_d   = sub_cout;
        idx_d     = idx_q + IDX_W'(1);
        if (last_nib) begin
          state_d    = S_DONE;
          diff_d     = result;
          borrow_d   = ~sub_cout;
          overflow_d = (a_r_q[WIDTH-1] != b_r_q[WIDTH-1]) &&
                       (result[WIDTH-1] != a_r_q[WIDTH-1]);
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
        if (start) begin
          a_r_d   = a;
          b_r_d   = b;
          idx_d   = '0;
          carry_d = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_r_q      <= '0;
      b_r_q      <= '0;
      diff_sh_q  <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_r_q      <= a_r_d;
      b_r_q      <= b_r_d;
      diff_sh_q  <= diff_sh_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_nibble_serial_subtractor_ctrl.sv
// Purpose: scoreboard bench for nibble_serial_subtractor_ctrl with a 4-bit ripple stage in the loop.
// Latency: expects done exactly 8 cycles after each accepting edge (WIDTH=32).
// Backpressure: none; start is driven one cycle at a time or held across DONE.
module tb_nibble_serial_subtractor_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow, overflow;
  logic [W-1:0] diff;
  logic [3:0]   sub_a, sub_b, sub_s;
  logic         sub_cin, sub_cout;

  always #5 clk = ~clk;

  nibble_serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .sub_cin  (sub_cin),
    .sub_s    (sub_s),
    .sub_cout (sub_cout)
  );

  // 4-bit ripple-carry stage, bit by bit.
  logic       rc;
  logic [3:0] rs;
  always_comb begin
    rc = sub_cin;
    rs = 4'd0;
    for (int i = 0; i < 4; i++) begin
      rs[i] = sub_a[i] ^ sub_b[i] ^ rc;
      rc    = (sub_a[i] & sub_b[i]) | (rc & (sub_a[i] ^ sub_b[i]));
    end
  end
  assign sub_s    = rs;
  assign sub_cout = rc;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] held_diff = '0;
  int           busy_run = 0;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int when);
    exp_t   e;
    longint sd;
    e.d   = x - y;
    e.br  = (x < y);
    sd    = longint'($signed(x)) - longint'($signed(y));
    e.ov  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    e.cyc = when;
    return e;
  endfunction

  // Output monitor: compares each done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) begin
        busy_run++;
        check("diff_hold_in_run", {32'd0, diff}, {32'd0, held_diff});
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("diff",     {32'd0, diff}, {32'd0, e.d});
          check("borrow",   {63'd0, borrow}, {63'd0, e.br});
          check("overflow", {63'd0, overflow}, {63'd0, e.ov});
          check("latency",  64'(cyc), 64'(e.cyc));
          check("busy_cycles", 64'(busy_run), 64'd8);
          check("busy_in_done", {63'd0, busy}, 64'd0);
          held_diff = e.d;
        end
        busy_run = 0;
      end
    end
  end

  // Call just after a rising edge; asserts start for one cycle, then scrambles a/b.
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    sb.push_back(model(x, y, cyc + 9));
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_all();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_pending_results", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_diff"},     {32'd0, diff}, 64'd0);
    check({tag, "_borrow"},   {63'd0, borrow}, 64'd0);
    check({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
    check({tag, "_busy"},     {63'd0, busy}, 64'd0);
    check({tag, "_done"},     {63'd0, done}, 64'd0);
    check({tag, "_sub_bus"},  {55'd0, sub_a, sub_b, sub_cin}, 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("reset");

    // Basic op plus first-nibble drive to the stage.
    drive_op(32'd5, 32'd3);
    check("sub_a_nib0",   {60'd0, sub_a}, 64'h5);
    check("sub_b_nib0",   {60'd0, sub_b}, 64'hC);
    check("sub_cin_nib0", {63'd0, sub_cin}, 64'd1);
    wait_all();
    check("idle_sub_bus", {55'd0, sub_a, sub_b, sub_cin}, 64'd0);

    drive_op(32'd0, 32'd1);
    wait_all();
    drive_op(32'h8000_0000, 32'd1);
    wait_all();

    // Reset while RUN is at idx=3.
    start = 1'b1;
    a     = 32'hAAAA_0000;
    b     = 32'h0000_0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    busy_run  = 0;
    held_diff = '0;
    check_quiet("midrun_reset");

    drive_op(32'h10, 32'h1);
    wait_all();

    // start re-pulsed during RUN must be ignored.
    drive_op(32'h1234_5678, 32'h1234_5678);
    @(posedge clk); #1;
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_all();

    // start held through DONE: back-to-back operation.
    start = 1'b1;
    a     = 32'h20;
    b     = 32'h5;
    sb.push_back(model(32'h20, 32'h5, cyc + 9));
    @(posedge clk); #1;
    a = 32'd7;
    b = 32'd7;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("done_before_b2b", {63'd0, done}, 64'd1);
    sb.push_back(model(32'd7, 32'd7, cyc + 9));
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_run_next", {63'd0, busy}, 64'd1);
    wait_all();

    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      y = (k == 2) ? x : $urandom;
      drive_op(x, y);
      wait_all();
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    check("final_scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
